rr_grant_arbiter: RTL



---
 rtl/rr_grant_arbiter_if.sv | 14 +
 rtl/rr_grant_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesting agents and rr_grant_arbiter.
// master: the requester side (drives req); slave: the arbiter side.
interface rr_grant_arbiter_if #(
   parameter int NREQ = 8
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [2:0]      gnt_id;
   logic            gnt_valid;
   logic            preempt;

   modport master (output req, input gnt, gnt_id, gnt_valid, preempt);
   modport slave  (input req, output gnt, gnt_id, gnt_valid, preempt);
endinterface

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter for up to eight requesters.
// Optional hold timeout compiled in with `define ARB_HOLD_TIMEOUT_EN; without
// it an owner keeps the grant until it drops req and preempt is tied low.
module rr_grant_arbiter #(
   parameter int NREQ     = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   rr_grant_arbiter_if.slave  bus
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Elaboration-time guard on the legal parameter ranges.
   if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
      $error("rr_grant_arbiter: NREQ must be 2..8 and MAX_HOLD 2..255");
   end

   logic [0:0]      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [2:0]      gnt_id_q, gnt_id_d;
   logic [2:0]      ptr_q, ptr_d;
   logic            vld_q, vld_d;

   logic [NREQ-1:0] cand;
   logic            win_found;
   logic [2:0]      win_id;
   logic            own_req;
   logic            issue;

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_q, hold_d;
   logic       preempt_q, preempt_d;
`endif

   // Rotating search: candidates at or above ptr first, then wrap to the low
   // indices. The current owner is masked out, so in IDLE (gnt_q = 0) this
   // is a plain search and in GRANT it only finds competitors.
   always_comb begin
      cand      = bus.req & ~gnt_q;
      win_found = 1'b0;
      win_id    = 3'd0;
      for (int j = 0; j < NREQ; j++) begin
         if (!win_found && cand[j] && (3'(j) >= ptr_q)) begin
            win_found = 1'b1;
            win_id    = 3'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!win_found && cand[j]) begin
            win_found = 1'b1;
            win_id    = 3'(j);
         end
      end
   end

   assign own_req = |(bus.req & gnt_q);

   // Next-state: decide whether to issue a new grant, keep, or go idle.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      issue     = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_d    = hold_q;
      preempt_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_found) issue = 1'b1;
         end
         default: begin
            if (!own_req) begin
               // Release wins over a coincident timeout, so no preempt here.
               if (win_found) begin
                  issue = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end
`ifdef ARB_HOLD_TIMEOUT_EN
            else if (hold_q == HOLD_LAST) begin
               // Saturated: rotate only if someone else is waiting.
               if (win_found) begin
                  issue     = 1'b1;
                  preempt_d = 1'b1;
               end
            end else begin
               hold_d = hold_q + 8'd1;
            end
`endif
         end
      endcase
      if (issue) begin
         state_d  = ST_GRANT;
         gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
         gnt_id_d = win_id;
         ptr_d    = (win_id == 3'(NREQ - 1)) ? 3'd0 : win_id + 3'd1;
`ifdef ARB_HOLD_TIMEOUT_EN
         hold_d   = 8'd0;
`endif
      end
      vld_d = |gnt_d;
   end

   // Arbiter state and registered outputs; reset overrides any grant.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= 3'd0;
         ptr_q    <= 3'd0;
         vld_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         ptr_q    <= ptr_d;
         vld_q    <= vld_d;
      end
   end

`ifdef ARB_HOLD_TIMEOUT_EN
   // Hold counter and the one-cycle preemption pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hold_q    <= 8'd0;
         preempt_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end
   assign bus.preempt = preempt_q;
`else
   assign bus.preempt = 1'b0;
`endif

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = vld_q;

endmodule
